// File: rtl/pipe_writeback_pkg.sv
// Shared types for the writeback stage: lane mask, register index, reservation ID
// and the buffered writeback entry.
package pipe_writeback_pkg;

  localparam int MASK_W        = 4;
  localparam int VREG_W        = 5;
  localparam int RSV_W         = 4;
  localparam int WB_FIFO_DEPTH = 4;

  typedef logic [MASK_W-1:0] Mask_t;
  typedef logic [VREG_W-1:0] VRegIdx_t;
  typedef logic [RSV_W-1:0]  RsvID_t;

  typedef struct packed {
    Mask_t    mask;
    VRegIdx_t vid;
    logic     typ;
    RsvID_t   rid;
  } WbEntry_t;

  // Index reached by stepping k places past ptr in an n-entry ring.
  function automatic int rr_index(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/pipe_writeback_if.sv
// Bundle between the execution pipes (master) and the writeback stage (slave):
// per-pipe op inputs, stall back-pressure, RF write port and retire pulses.
interface pipe_writeback_if #(
  parameter int NumPipes = 2
);
  import pipe_writeback_pkg::*;

  logic     [NumPipes-1:0] iOpValid;
  Mask_t    [NumPipes-1:0] iMask;
  logic     [NumPipes-1:0] iDstRegValid;
  VRegIdx_t [NumPipes-1:0] iDstRegVID;
  logic     [NumPipes-1:0] iDstRegType;
  RsvID_t   [NumPipes-1:0] iRID;
  logic     [NumPipes-1:0] oStall;
  logic                    oWbValid;
  Mask_t                   oWbMask;
  VRegIdx_t                oWbVID;
  logic                    oWbType;
  RsvID_t                  oWbRID;
  logic     [NumPipes-1:0] oRetire;

  modport master (
    output iOpValid, iMask, iDstRegValid, iDstRegVID, iDstRegType, iRID,
    input  oStall, oWbValid, oWbMask, oWbVID, oWbType, oWbRID, oRetire
  );

  modport slave (
    input  iOpValid, iMask, iDstRegValid, iDstRegVID, iDstRegType, iRID,
    output oStall, oWbValid, oWbMask, oWbVID, oWbType, oWbRID, oRetire
  );

endinterface

// File: rtl/pipe_writeback_wb_fifo.sv
// Per-pipe synchronous FIFO of writeback entries with a combinational head so the
// arbiter can pop an entry the cycle after it was pushed.
module wb_fifo
  import pipe_writeback_pkg::*;
#(
  parameter int Depth = WB_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  WbEntry_t push_data_i,
  input  logic     pop_i,
  output WbEntry_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  WbEntry_t        mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pipe_writeback.sv
// Collects completed ops from several pipes, buffers them per pipe and round-robins
// them onto the single vector-RF write port, emitting per-pipe retire pulses.
module pipe_writeback
  import pipe_writeback_pkg::*;
#(
  parameter int NumPipes  = 2,
  parameter int FifoDepth = WB_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  pipe_writeback_if.slave  bus
);

  localparam int PW = (NumPipes > 1) ? $clog2(NumPipes) : 1;
  localparam int CW = $clog2(FifoDepth) + 1;

  logic [NumPipes-1:0] full;
  logic [NumPipes-1:0] empty;
  logic [NumPipes-1:0] accept;
  logic [NumPipes-1:0] push;
  logic [NumPipes-1:0] no_dst;
  logic [NumPipes-1:0] pop;
  logic [NumPipes-1:0] retire_d;
  WbEntry_t            head [NumPipes];

  logic                grant_valid;
  logic [PW-1:0]       grant_idx;
  int                  scan_idx;

  logic                wb_valid_q;
  WbEntry_t            wb_entry_q;
  logic [NumPipes-1:0] retire_q;
  logic [PW-1:0]       rr_ptr_q;

  generate
    for (genvar gi = 0; gi < NumPipes; gi++) begin : g_pipe
      WbEntry_t      push_entry;
      logic [CW-1:0] pend_q;
      logic [CW-1:0] pend_d;
      logic [CW:0]   retire_total;

      // Stall depends only on registered occupancy, never on this cycle's pop.
      assign accept[gi] = bus.iOpValid[gi] && !full[gi];
      assign push[gi]   = accept[gi] && bus.iDstRegValid[gi];
      assign no_dst[gi] = accept[gi] && !bus.iDstRegValid[gi];
      assign pop[gi]    = grant_valid && (grant_idx == PW'(gi));

      assign push_entry.mask = bus.iMask[gi];
      assign push_entry.vid  = bus.iDstRegVID[gi];
      assign push_entry.typ  = bus.iDstRegType[gi];
      assign push_entry.rid  = bus.iRID[gi];

      wb_fifo #(
        .Depth (FifoDepth)
      ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push[gi]),
        .push_data_i (push_entry),
        .pop_i       (pop[gi]),
        .head_o      (head[gi]),
        .full_o      (full[gi]),
        .empty_o     (empty[gi])
      );

      // One retire pulse per cycle; extra events (writeback grant and a no-dst
      // accept landing together) are carried over and released on later cycles.
      assign retire_total = (CW+1)'(pend_q) + (CW+1)'(pop[gi]) + (CW+1)'(no_dst[gi]);

      always_comb begin
        retire_d[gi] = (retire_total != '0);
        pend_d       = '0;
        if (retire_total != '0) pend_d = CW'(retire_total - (CW+1)'(1));
      end

      always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
      end
    end
  endgenerate

  // Round-robin: first non-empty FIFO after the last granted pipe.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NumPipes; k++) begin
      scan_idx = rr_index(int'(rr_ptr_q), k, NumPipes);
      if (!grant_valid && !empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_entry_q <= '0;
      retire_q   <= '0;
      rr_ptr_q   <= PW'(NumPipes - 1);
    end else begin
      wb_valid_q <= grant_valid;
      retire_q   <= retire_d;
      if (grant_valid) begin
        wb_entry_q <= head[grant_idx];
        rr_ptr_q   <= grant_idx;
      end
    end
  end

  assign bus.oStall   = full;
  assign bus.oWbValid = wb_valid_q;
  assign bus.oWbMask  = wb_entry_q.mask;
  assign bus.oWbVID   = wb_entry_q.vid;
  assign bus.oWbType  = wb_entry_q.typ;
  assign bus.oWbRID   = wb_entry_q.rid;
  assign bus.oRetire  = retire_q;

endmodule

// File: tb/tb_pipe_writeback.sv
// Scoreboard bench for pipe_writeback: two pipes, per-pipe expected-entry queues
// filled on accept and drained on each RF write, plus retire-timing logs.
module tb_pipe_writeback;
  import pipe_writeback_pkg::*;

  localparam int NP = 2;

  typedef struct {
    logic     dst;
    WbEntry_t e;
  } op_t;

  typedef struct {
    WbEntry_t e;
    int       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_writeback_if #(.NumPipes(NP)) pif ();

  pipe_writeback #(
    .NumPipes  (NP),
    .FifoDepth (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  op_t  send_q  [NP][$];
  exp_t exp_q   [NP][$];
  int   ret_log [NP][$];
  int   acc_log [NP][$];
  int   wb_pipes[$];
  int   wb_vids [$];
  int   exp_ret [NP];
  int   obs_ret [NP];
  bit   adv     [NP];
  bit   seen_stall [NP];
  bit   held9;
  bit   lat_chk;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare writes against the scoreboard, log retires, record accepts.
  always @(negedge clk) begin
    int       p;
    WbEntry_t got;
    exp_t     ex;
    if (pif.oWbValid) begin
      p   = int'(pif.oWbRID[3]);
      got = {pif.oWbMask, pif.oWbVID, pif.oWbType, pif.oWbRID};
      wb_pipes.push_back(p);
      wb_vids.push_back(int'(pif.oWbVID));
      $display("cyc %0d WB pipe%0d vid=%0d rid=%0h mask=%0h retire=%b",
               cyc, p, pif.oWbVID, pif.oWbRID, pif.oWbMask, pif.oRetire);
      if (exp_q[p].size() == 0) begin
        check_value("wb_unexpected", exp_q[p].size(), 1);
      end else begin
        ex = exp_q[p].pop_front();
        check_value("wb_entry", 32'(got), 32'(ex.e));
        check_value("wb_retire_bit", 32'(pif.oRetire[p]), 1);
        if (lat_chk) check_value("wb_latency", cyc - ex.cyc, 2);
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (pif.oRetire[i]) begin
        obs_ret[i]++;
        ret_log[i].push_back(cyc);
      end
      if (pif.oStall[i]) seen_stall[i] = 1'b1;
      if (!rst && pif.iOpValid[i] && !pif.oStall[i]) begin
        acc_log[i].push_back(cyc);
        exp_ret[i]++;
        if (pif.iDstRegValid[i]) begin
          ex.e   = {pif.iMask[i], pif.iDstRegVID[i], pif.iDstRegType[i], pif.iRID[i]};
          ex.cyc = cyc;
          exp_q[i].push_back(ex);
        end
        adv[i] = 1'b1;
      end
    end
    if (pif.iOpValid[0] && pif.oStall[0] && pif.iDstRegVID[0] == VRegIdx_t'(9)) held9 = 1'b1;
  end

  // Pipe model: hold each op until accepted, then present the next one.
  initial begin
    op_t o;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        for (int i = 0; i < NP; i++) begin
          if (adv[i] || !pif.iOpValid[i]) begin
            adv[i] = 1'b0;
            if (send_q[i].size() > 0) begin
              o = send_q[i].pop_front();
              pif.iOpValid[i]     = 1'b1;
              pif.iDstRegValid[i] = o.dst;
              pif.iMask[i]        = o.e.mask;
              pif.iDstRegVID[i]   = o.e.vid;
              pif.iDstRegType[i]  = o.e.typ;
              pif.iRID[i]         = o.e.rid;
            end else begin
              pif.iOpValid[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic add_op(input int p, input bit dst, input int vid, input int seq, input int mask);
    op_t o;
    o.dst    = dst;
    o.e.mask = Mask_t'(mask);
    o.e.vid  = VRegIdx_t'(vid);
    o.e.typ  = seq[0];
    o.e.rid  = RsvID_t'({p[0], seq[2:0]});
    send_q[p].push_back(o);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NP; i++) begin
      ret_log[i].delete();
      acc_log[i].delete();
      exp_ret[i]    = 0;
      obs_ret[i]    = 0;
      seen_stall[i] = 1'b0;
    end
    wb_pipes.delete();
    wb_vids.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((send_q[0].size() + send_q[1].size() + exp_q[0].size() + exp_q[1].size() > 0 ||
            pif.iOpValid != '0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_value({tag, "_drain"}, 32'(n < 500), 1);
    repeat (4) @(posedge clk);
    for (int i = 0; i < NP; i++) check_value({tag, "_retire_count"}, obs_ret[i], exp_ret[i]);
  endtask

  function automatic int log_diff(input int p, input int idx);
    if (ret_log[p].size() > idx && acc_log[p].size() > 0) return ret_log[p][idx] - acc_log[p][0];
    return -1;
  endfunction

  initial begin
    int n;
    int nine;
    pif.iOpValid = '0; pif.iMask = '0; pif.iDstRegValid = '0;
    pif.iDstRegVID = '0; pif.iDstRegType = '0; pif.iRID = '0;
    held9 = 1'b0; lat_chk = 1'b0;
    for (int i = 0; i < NP; i++) adv[i] = 1'b0;
    clear_logs();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_value("reset_wbvalid", 32'(pif.oWbValid), 0);
    check_value("reset_retire", 32'(pif.oRetire), 0);
    check_value("reset_stall", 32'(pif.oStall), 0);
    check_value("reset_data", 32'({pif.oWbMask, pif.oWbVID, pif.oWbType, pif.oWbRID}), 0);

    // 1: single op, fixed latency
    @(posedge clk); clear_logs(); lat_chk = 1'b1;
    add_op(0, 1'b1, 5, 2, 15);
    wait_idle("t1");
    lat_chk = 1'b0;
    check_value("t1_writes", wb_vids.size(), 1);
    check_value("t1_retire_lat", log_diff(0, 0), 2);
    check_value("t1_p1_retires", ret_log[1].size(), 0);

    // 3: no-destination op retires next cycle without a write
    clear_logs();
    add_op(1, 1'b0, 7, 3, 9);
    wait_idle("t3");
    check_value("t3_writes", wb_vids.size(), 0);
    check_value("t3_retire_lat", log_diff(1, 0), 1);
    check_value("t3_p0_retires", ret_log[0].size(), 0);

    // 2: both pipes streaming
    clear_logs();
    for (int k = 0; k < 32; k++) begin
      add_op(0, 1'b1, 1 + k % 8, k, $urandom_range(1, 15));
      add_op(1, 1'b1, 11 + k % 8, k, $urandom_range(1, 15));
    end
    wait_idle("t2");
    check_value("t2_writes", wb_pipes.size(), 64);
    for (int k = 1; k < wb_pipes.size(); k++) check_value("t2_alternate", wb_pipes[k], 1 - wb_pipes[k-1]);
    check_value("t2_stall0_seen", 32'(seen_stall[0]), 1);
    check_value("t2_stall1_seen", 32'(seen_stall[1]), 1);

    // 4: op held while stalled is written exactly once
    clear_logs(); held9 = 1'b0;
    for (int k = 0; k < 8; k++) add_op(0, 1'b1, 1 + k, k, 5);
    add_op(0, 1'b1, 9, 0, 6);
    for (int k = 0; k < 12; k++) add_op(1, 1'b1, 11 + k, k, 3);
    wait_idle("t4");
    nine = 0;
    for (int k = 0; k < wb_vids.size(); k++) if (wb_vids[k] == 9 && wb_pipes[k] == 0) nine++;
    check_value("t4_vid9_once", nine, 1);
    check_value("t4_held_while_stalled", 32'(held9), 1);
    check_value("t4_stall0_seen", 32'(seen_stall[0]), 1);

    // 5: no-dst accept coinciding with a writeback grant on the same pipe
    clear_logs();
    add_op(0, 1'b1, 3, 0, 12);
    add_op(0, 1'b0, 4, 1, 12);
    wait_idle("t5");
    check_value("t5_retire_pulses", ret_log[0].size(), 2);
    check_value("t5_first_pulse", log_diff(0, 0), 2);
    check_value("t5_second_pulse", log_diff(0, 1), 3);

    // 6: reset with entries buffered
    clear_logs();
    for (int k = 0; k < 3; k++) add_op(0, 1'b1, 20 + k, k, 7);
    for (int k = 0; k < 2; k++) add_op(1, 1'b1, 24 + k, k, 7);
    n = 0;
    while (acc_log[0].size() < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check_value("t6_fill", 32'(n < 50), 1);
    #1 rst = 1'b1;
    pif.iOpValid = '0;
    for (int i = 0; i < NP; i++) begin send_q[i].delete(); adv[i] = 1'b0; end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NP; i++) exp_q[i].delete();
    clear_logs();
    @(negedge clk);
    check_value("t6_wbvalid", 32'(pif.oWbValid), 0);
    check_value("t6_retire", 32'(pif.oRetire), 0);
    check_value("t6_stall", 32'(pif.oStall), 0);
    check_value("t6_data", 32'({pif.oWbMask, pif.oWbVID, pif.oWbType, pif.oWbRID}), 0);
    repeat (6) @(posedge clk);
    check_value("t6_no_writes", wb_vids.size(), 0);
    check_value("t6_no_retires", obs_ret[0] + obs_ret[1], 0);
    add_op(0, 1'b1, 30, 5, 1);
    add_op(1, 1'b1, 31, 6, 2);
    wait_idle("t6b");
    check_value("t6_writes", wb_pipes.size(), 2);
    check_value("t6_first_pipe0", (wb_pipes.size() > 0) ? wb_pipes[0] : -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
